// File: rtl/iir_out_buffer.sv
// iir_out_buffer: output stage of the IIR filter core.
// Captures every sample the filter emits (in_wen/in_addr/in_data) into a small
// FIFO and drains it to the result memory over a req/ack handshake, so a slow
// memory never stalls the filter. The filter cannot be back-pressured, so a
// sample arriving while the FIFO is full is dropped and overflow is latched.
// Once in_finish is seen and the FIFO has drained, done is raised.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_wen          sample strobe from the filter
//   in_data/in_addr sample value and destination address
//   in_finish       end-of-stream level from the filter
//   mem_req         write request, held until mem_ack
//   mem_addr/data   write address/data, valid while mem_req=1
//   mem_ack         memory accepted the current write
//   overflow        sticky: at least one sample was dropped
//   wr_count        number of completed memory writes (wraps)
//   done            run complete, every accepted sample written
module iir_out_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 20,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_wen,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_addr,
  input  logic          in_finish,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic          mem_ack,
  output logic          overflow,
  output logic [AW-1:0] wr_count,
  output logic          done
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = AW + DW;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e             state_q;
  logic [EntW-1:0]    fifo_mem [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CntW-1:0]    count_q;
  logic               fin_q;
  logic               full, pop, push, drop;
  logic [EntW-1:0]    head, next_head;

  assign full       = (count_q == CntW'(DEPTH));
  assign pop        = (state_q == StReq) && mem_ack;
  // A full FIFO still accepts a sample when the head leaves on the same edge.
  assign push       = in_wen && !fin_q && (!full || pop);
  assign drop       = in_wen && !fin_q && full && !pop;
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;
  assign head       = fifo_mem[rd_ptr_q];
  // After a pop the next head is the following entry, or, when only one entry
  // was held, the sample being pushed on this same edge.
  assign next_head  = (count_q > CntW'(1)) ? fifo_mem[rd_ptr_nxt] : {in_addr, in_data};

  // Sample storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_addr, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fin_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (in_finish) begin
        fin_q <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Write-side FSM; all memory-facing outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      wr_count <= '0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q              <= StReq;
            mem_req              <= 1'b1;
            {mem_addr, mem_data} <= head;
          end else if (fin_q) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StReq: begin
          if (mem_ack) begin
            wr_count <= wr_count + AW'(1);
            if ((count_q > CntW'(1)) || push) begin
              {mem_addr, mem_data} <= next_head;
            end else begin
              state_q <= StIdle;
              mem_req <= 1'b0;
            end
          end
        end
        StDone: begin
          mem_req <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_out_buffer.sv
// Self-checking bench for iir_out_buffer. A queue-based reference model decides
// which samples are accepted and pushes them onto a scoreboard; a separate
// monitor pops and compares every completed memory write.
module tb_iir_out_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_wen = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  logic          in_finish = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ack = 1'b0;
  logic          overflow;
  logic [AW-1:0] wr_count;
  logic          done;

  iir_out_buffer #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_wen   (in_wen),
    .in_data  (in_data),
    .in_addr  (in_addr),
    .in_finish(in_finish),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .overflow (overflow),
    .wr_count (wr_count),
    .done     (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard of expected writes, in order.
  logic [AW+DW-1:0] exp_q[$];

  // Reference model state, as seen between clock edges.
  int occ    = 0;   // samples accepted but not yet written
  bit req_m  = 0;   // a write should be on offer
  bit done_m = 0;
  bit ovf_m  = 0;
  bit fin_m  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; outputs are compared to the model before inputs move.
  task automatic step(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic fin, input logic ack);
    bit pop, acc, req_nx, done_nx;
    int occ_new;
    @(negedge clk);
    chk("mem_req", mem_req, req_m);
    chk("done", done, done_m);
    chk("overflow", overflow, ovf_m);
    in_wen = wen; in_addr = a; in_data = d; in_finish = fin; mem_ack = ack;
    pop = req_m && ack;
    acc = wen && !fin_m && ((occ < DEPTH) || pop);
    if (wen && !fin_m && !acc) ovf_m = 1;
    if (acc) exp_q.push_back({a, d});
    occ_new = occ + int'(acc) - int'(pop);
    if (done_m)     req_nx = 0;
    else if (req_m) req_nx = !ack || (occ_new > 0);
    else            req_nx = (occ > 0);
    done_nx = done_m || (!req_m && (occ == 0) && fin_m);
    occ    = occ_new;
    req_m  = req_nx;
    done_m = done_nx;
    if (fin) fin_m = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_wen = 0; in_finish = 0; mem_ack = 0; in_addr = '0; in_data = '0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_done", done, 0);
    occ = 0; req_m = 0; done_m = 0; ovf_m = 0; fin_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // ackmode 1: always ack; otherwise ack roughly one cycle in three.
  task automatic drain(input int ackmode);
    int n;
    n = 0;
    while ((occ != 0 || req_m) && n < 400) begin
      step(0, '0, '0, 0, (ackmode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0));
      n++;
    end
    chk("drain_timeout", (occ != 0 || req_m), 0);
    @(negedge clk); #2;
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  // Monitor: compares each completed write and checks hold-while-stalled.
  initial begin
    int hs_cnt;
    bit stall_v;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;
    logic [AW+DW-1:0] e;
    hs_cnt = 0; stall_v = 0; held_a = '0; held_d = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        exp_q.delete();
        hs_cnt = 0;
        stall_v = 0;
      end else begin
        chk("wr_count_track", wr_count, AW'(hs_cnt));
        if (stall_v && mem_req) begin
          chk("stall_addr_stable", mem_addr, held_a);
          chk("stall_data_stable", mem_data, held_d);
        end
        if (mem_req && mem_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {mem_addr, mem_data}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", mem_addr, e[AW+DW-1:DW]);
            chk("write_data", mem_data, e[DW-1:0]);
          end
          hs_cnt++;
        end
        stall_v = mem_req && !mem_ack;
        held_a = mem_addr;
        held_d = mem_data;
      end
    end
  end

  initial begin
    int ph;
    do_reset();

    // Five back-to-back writes, then finish.
    for (int i = 0; i < 5; i++) step(1, AW'(i), DW'(16'h0010 + i), 0, 1);
    drain(1);
    chk("p1_wr_count", wr_count, 5);
    chk("p1_overflow", overflow, 0);
    step(0, '0, '0, 1, 1);
    step(0, '0, '0, 1, 1);
    step(0, '0, '0, 1, 1);
    chk("p1_done", done, 1);

    // Ten samples against a stalled memory: two dropped.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, AW'(i), DW'($urandom), 0, 0);
    step(0, '0, '0, 0, 0);
    chk("p2_overflow", overflow, 1);
    drain(1);
    chk("p2_wr_count", wr_count, 8);

    // Full FIFO with a simultaneous pop accepts the push; it stays full.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, AW'(i + 32), DW'($urandom), 0, 0);
    step(1, AW'(16'h55), DW'($urandom), 0, 1);
    step(0, '0, '0, 0, 0);
    chk("p3_overflow_kept_0", overflow, 0);
    step(1, AW'(16'h66), DW'($urandom), 0, 0);
    step(0, '0, '0, 0, 0);
    chk("p3_full_drop", overflow, 1);
    drain(2);
    chk("p3_wr_count", wr_count, 9);

    // 20-sample stream, in_wen every third cycle, ack one cycle in three.
    do_reset();
    ph = $urandom_range(0, 2);
    for (int c = 0; c < 60; c++) begin
      step((c % 3) == 0, AW'($urandom), DW'($urandom), 0, (c % 3) == ph);
    end
    drain(2);
    chk("p4_wr_count", wr_count, 20);
    chk("p4_overflow", overflow, 0);

    // Finish with four writes pending; later samples ignored.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, AW'(i + 100), DW'($urandom), 0, 0);
    step(0, '0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, AW'(i + 200), DW'($urandom), 1, 0);
    for (int i = 0; i < 8; i++) step(1, AW'(i + 300), DW'($urandom), 1, 1);
    chk("p5_done", done, 1);
    chk("p5_wr_count", wr_count, 4);
    chk("p5_overflow", overflow, 0);

    // Reset mid-request with three pending, then a fresh run.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, AW'(i + 7), DW'($urandom), 0, 0);
    step(0, '0, '0, 0, 0);
    chk("p6_req_before_reset", mem_req, 1);
    do_reset();
    step(1, AW'(20'h00100), DW'($urandom), 0, 1);
    drain(1);
    chk("p6_wr_count", wr_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
